// File: rtl/bus_mux_reg.sv
// Registered CPU datapath bus: lowest-index one-hot source select with contention tracking.
// Latency: 1 cycle from strobes/data to bus_out, bus_src, bus_valid and contention flags.
// Backpressure: none; every cycle's strobes are consumed, and consumers sample bus_out freely.
module bus_mux_reg #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 24,
    parameter int HOLD_EN = 1,
    parameter int CNT_W   = 8,
    localparam int SEL_W  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic [NSRC-1:0]         src_out,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_valid,
    output logic [SEL_W-1:0]        bus_src,
    output logic                    contention,
    output logic                    contention_sticky,
    output logic [CNT_W-1:0]        contention_cnt
);

    localparam logic [NSRC-1:0]  SRC_ONE = NSRC'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             vld_q, vld_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic             con_q, con_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             any_drv;
    logic             multi_drv;
    logic [SEL_W-1:0] win_idx;
    logic [WIDTH-1:0] win_word;

    // Priority pick: scan high to low so the lowest set strobe is the last writer.
    // Multiple strobes are detected by clearing the lowest set bit and testing what remains.
    always_comb begin
        win_idx   = '0;
        win_word  = '0;
        any_drv   = |src_out;
        multi_drv = |(src_out & (src_out - SRC_ONE));
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                win_idx  = SEL_W'(i);
                win_word = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for bus capture and the contention pulse/sticky/saturating counter.
    always_comb begin
        bus_d    = bus_q;
        src_d    = src_q;
        vld_d    = 1'b0;
        con_d    = multi_drv;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (any_drv) begin
            bus_d = win_word;
            src_d = win_idx;
            vld_d = 1'b1;
        end else if (HOLD_EN == 0) begin
            bus_d = '0;
            src_d = '0;
        end

        // A fresh contention event outranks err_clr so it is never lost.
        if (multi_drv) begin
            sticky_d = 1'b1;
            if (err_clr) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (err_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    // State registers with synchronous clear that overrides every other input.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_q    <= '0;
            vld_q    <= 1'b0;
            src_q    <= '0;
            con_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bus_q    <= bus_d;
            vld_q    <= vld_d;
            src_q    <= src_d;
            con_q    <= con_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus_out           = bus_q;
    assign bus_valid         = vld_q;
    assign bus_src           = src_q;
    assign contention        = con_q;
    assign contention_sticky = sticky_q;
    assign contention_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: two instances (hold/8-bit counter, no-hold/2-bit counter) share stimulus.
// Latency: outputs checked 1 time unit after each rising edge against a behavioural model.
// Backpressure: not applicable; directed cases are followed by randomized strobe patterns.
module tb_bus_mux_reg;

    localparam int WIDTH = 32;
    localparam int NSRC  = 24;
    localparam int SEL_W = 5;

    logic                  clock = 1'b0;
    logic                  clear;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_out;
    logic                  err_clr;

    logic [WIDTH-1:0] bus0, bus1;
    logic             vld0, vld1;
    logic [SEL_W-1:0] src0, src1;
    logic             con0, con1;
    logic             stk0, stk1;
    logic [7:0]       cnt0;
    logic [1:0]       cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, one slot per instance.
    logic [31:0] m_bus    [2];
    int          m_src    [2];
    bit          m_vld    [2];
    bit          m_con    [2];
    bit          m_sticky [2];
    int          m_cnt    [2];
    bit          hold     [2] = '{1'b1, 1'b0};
    int          cnt_max  [2] = '{255, 3};

    always #5 clock = ~clock;

    bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_EN(1), .CNT_W(8)) dut0 (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .err_clr(err_clr), .bus_out(bus0), .bus_valid(vld0), .bus_src(src0),
        .contention(con0), .contention_sticky(stk0), .contention_cnt(cnt0)
    );

    bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_EN(0), .CNT_W(2)) dut1 (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .err_clr(err_clr), .bus_out(bus1), .bus_valid(vld1), .bus_src(src1),
        .contention(con1), .contention_sticky(stk1), .contention_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model update from the inputs presented at this edge.
    task automatic model_step();
        int n;
        int k;
        n = $countones(src_out);
        k = 0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_out[i]) begin
                k = i;
                break;
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (clear) begin
                m_bus[d] = 0; m_src[d] = 0; m_vld[d] = 0;
                m_con[d] = 0; m_sticky[d] = 0; m_cnt[d] = 0;
            end else begin
                if (n > 0) begin
                    m_bus[d] = src_data[k*WIDTH +: WIDTH];
                    m_src[d] = k;
                    m_vld[d] = 1;
                end else begin
                    m_vld[d] = 0;
                    if (!hold[d]) begin
                        m_bus[d] = 0;
                        m_src[d] = 0;
                    end
                end
                m_con[d] = (n >= 2);
                if (n >= 2) begin
                    m_sticky[d] = 1;
                    m_cnt[d] = err_clr ? 1 : ((m_cnt[d] + 1 > cnt_max[d]) ? cnt_max[d] : m_cnt[d] + 1);
                end else if (err_clr) begin
                    m_sticky[d] = 0;
                    m_cnt[d] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bus0"}, 64'(bus0), 64'(m_bus[0]));
        chk({tag, ".vld0"}, 64'(vld0), 64'(m_vld[0]));
        chk({tag, ".src0"}, 64'(src0), 64'(m_src[0]));
        chk({tag, ".con0"}, 64'(con0), 64'(m_con[0]));
        chk({tag, ".stk0"}, 64'(stk0), 64'(m_sticky[0]));
        chk({tag, ".cnt0"}, 64'(cnt0), 64'(m_cnt[0]));
        chk({tag, ".bus1"}, 64'(bus1), 64'(m_bus[1]));
        chk({tag, ".vld1"}, 64'(vld1), 64'(m_vld[1]));
        chk({tag, ".src1"}, 64'(src1), 64'(m_src[1]));
        chk({tag, ".con1"}, 64'(con1), 64'(m_con[1]));
        chk({tag, ".stk1"}, 64'(stk1), 64'(m_sticky[1]));
        chk({tag, ".cnt1"}, 64'(cnt1), 64'(m_cnt[1]));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = $urandom;
    endtask

    task automatic drive(input logic [NSRC-1:0] s, input logic e);
        src_out = s;
        err_clr = e;
    endtask

    initial begin
        logic [NSRC-1:0] s;
        clear = 1'b1;
        err_clr = 1'b0;
        src_out = '0;
        rand_data();
        for (int d = 0; d < 2; d++) begin
            m_bus[d] = 0; m_src[d] = 0; m_vld[d] = 0;
            m_con[d] = 0; m_sticky[d] = 0; m_cnt[d] = 0;
        end

        // Reset with random strobes active.
        for (int c = 0; c < 2; c++) begin
            drive(NSRC'($urandom) | NSRC'(3), 1'b1);
            step("reset");
        end
        chk("reset.bus0_zero", 64'(bus0), 64'd0);
        chk("reset.cnt0_zero", 64'(cnt0), 64'd0);
        clear = 1'b0;

        // Single drive from PC.
        src_data[20*WIDTH +: WIDTH] = 32'h0000_0040;
        drive(NSRC'(1) << 20, 1'b0);
        step("single");
        chk("single.bus", 64'(bus0), 64'h40);
        chk("single.src", 64'(src0), 64'd20);

        // Idle: hold on dut0, zero on dut1.
        drive('0, 1'b0);
        step("idle");
        chk("idle.hold", 64'(bus0), 64'h40);
        chk("idle.nohold", 64'(bus1), 64'h0);

        // Contention between R3 and bit 21.
        src_data[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        drive((NSRC'(1) << 3) | (NSRC'(1) << 21), 1'b0);
        step("cont");
        chk("cont.bus", 64'(bus0), 64'hDEAD_BEEF);
        chk("cont.cnt", 64'(cnt0), 64'd1);
        drive('0, 1'b0);
        step("cont_pulse_end");
        chk("cont.pulse_off", 64'(con0), 64'd0);

        // Saturation: five more contention cycles.
        for (int c = 0; c < 5; c++) begin
            rand_data();
            drive((NSRC'(1) << (c + 1)) | (NSRC'(1) << 23), 1'b0);
            step("sat");
        end
        chk("sat.cnt1", 64'(cnt1), 64'd3);
        chk("sat.cnt0", 64'(cnt0), 64'd6);

        drive('0, 1'b1);
        step("errclr");
        chk("errclr.stk", 64'(stk1), 64'd0);
        drive(NSRC'(5), 1'b1);
        step("errclr_cont");
        chk("errclr_cont.cnt", 64'(cnt1), 64'd1);

        // Sweep every source alone.
        for (int i = 0; i < NSRC; i++) begin
            src_data[i*WIDTH +: WIDTH] = 32'hA5A5_0000 + i;
            drive(NSRC'(1) << i, 1'b0);
            step("sweep");
            chk("sweep.src", 64'(src0), 64'(i));
        end

        // Clear in the middle of a contended transfer.
        drive(NSRC'(6), 1'b0);
        clear = 1'b1;
        step("midclear");
        clear = 1'b0;

        // Randomized mix of idle, single, paired and arbitrary strobe patterns.
        for (int c = 0; c < 400; c++) begin
            rand_data();
            case ($urandom_range(0, 3))
                0: s = '0;
                1: s = NSRC'(1) << $urandom_range(0, NSRC - 1);
                2: s = (NSRC'(1) << $urandom_range(0, NSRC - 1)) | (NSRC'(1) << $urandom_range(0, NSRC - 1));
                default: s = NSRC'($urandom);
            endcase
            drive(s, ($urandom_range(0, 7) == 0));
            clear = ($urandom_range(0, 49) == 0);
            step("rand");
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
